act_ring_mem: RTL and testbench

- Parametrised successor to the two-bank ping-pong activation memory: NBANK single-port banks (DATA_W x 2^ADDR_W each), organised as a ring.
- The layer-output writer fills one bank while the systolic/weight-update reader consumes a previously completed bank.
- Bank rotation is driven by explicit end-of-layer (wr_last) and release (rd_release) handshakes, replacing external per-bank enables.
- Read data is pipelined with a valid strobe.

---
 rtl/act_ring_mem.sv | 181 ++++++++++++++++++
 tb/tb_act_ring_mem.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_ring_mem.sv
// Ring of NBANK single-port activation banks: the writer fills one bank per layer while
// the reader drains completed banks. Read responses are pipelined with a valid strobe.
module act_ring_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned NBANK  = 2,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         wr_last,
  output logic                         wr_ready,
  input  logic                         rd_valid,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic                         rd_ready,
  input  logic                         rd_release,
  output logic                         rd_rsp_valid,
  output logic [DATA_W-1:0]            rd_rsp_data,
  output logic [$clog2(NBANK)-1:0]     wr_bank,
  output logic [$clog2(NBANK)-1:0]     rd_bank,
  output logic [$clog2(NBANK+1)-1:0]   filled,
  output logic [ADDR_W:0]              wr_words,
  output logic                         err
);

  localparam int unsigned BW    = $clog2(NBANK);
  localparam int unsigned FW    = $clog2(NBANK + 1);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [BW-1:0]   LAST_BANK = BW'(NBANK - 1);
  localparam logic [FW-1:0]   FULL      = FW'(NBANK);
  localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic [BW-1:0]   wr_bank_q, wr_bank_d;
  logic [BW-1:0]   rd_bank_q, rd_bank_d;
  logic [FW-1:0]   filled_q, filled_d;
  logic [ADDR_W:0] wr_words_q, wr_words_d;
  logic            err_q, err_d;

  logic wr_acc, rd_acc, rel_acc, layer_done;

  assign wr_ready   = (filled_q < FULL);
  assign rd_ready   = (filled_q != '0);
  assign wr_acc     = wr_valid && wr_ready;
  assign rd_acc     = rd_valid && rd_ready;
  assign rel_acc    = rd_release && rd_ready;
  assign layer_done = wr_acc && wr_last;

  always_comb begin
    wr_bank_d = wr_bank_q;
    if (layer_done) begin
      wr_bank_d = (wr_bank_q == LAST_BANK) ? '0 : wr_bank_q + 1'b1;
    end

    rd_bank_d = rd_bank_q;
    if (rel_acc) begin
      rd_bank_d = (rd_bank_q == LAST_BANK) ? '0 : rd_bank_q + 1'b1;
    end

    // Completing a layer and releasing a bank in the same cycle cancel out.
    filled_d = filled_q;
    case ({layer_done, rel_acc})
      2'b10:   filled_d = filled_q + 1'b1;
      2'b01:   filled_d = filled_q - 1'b1;
      default: filled_d = filled_q;
    endcase

    wr_words_d = wr_words_q;
    if (wr_acc) begin
      if (wr_last) begin
        wr_words_d = '0;
      end else if (wr_words_q != WORDS_MAX) begin
        wr_words_d = wr_words_q + 1'b1;
      end
    end

    err_d = err_q
          | (rd_release && !rd_ready)
          | (wr_valid && !wr_ready)
          | (rd_valid && !rd_ready)
          | (wr_acc && (wr_words_q == WORDS_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q  <= '0;
      rd_bank_q  <= '0;
      filled_q   <= '0;
      wr_words_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      filled_q   <= filled_d;
      wr_words_q <= wr_words_d;
      err_q      <= err_d;
    end
  end

  assign wr_bank  = wr_bank_q;
  assign rd_bank  = rd_bank_q;
  assign filled   = filled_q;
  assign wr_words = wr_words_q;
  assign err      = err_q;

  // Legal writes and reads never target the same bank, so each bank sees at most
  // one enabled port per cycle.
  logic [DATA_W-1:0] bank_rdata [NBANK];

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic              we;
    logic              re;

    assign we = wr_acc && (wr_bank_q == BW'(b));
    assign re = rd_acc && (rd_bank_q == BW'(b));

    always_ff @(posedge clk) begin
      if (we) begin
        mem[wr_addr] <= wr_data;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q <= '0;
      end else if (re) begin
        rdata_q <= mem[rd_addr];
      end
    end

    assign bank_rdata[b] = rdata_q;
  end

  logic [BW-1:0]     rd_sel_q;
  logic              rsp_v1_q;
  logic [DATA_W-1:0] bank_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sel_q <= '0;
      rsp_v1_q <= 1'b0;
    end else begin
      rsp_v1_q <= rd_acc;
      if (rd_acc) begin
        rd_sel_q <= rd_bank_q;
      end
    end
  end

  // Select only moves on a new read, so the stage-1 data holds between responses.
  assign bank_out = bank_rdata[rd_sel_q];

  if (RD_LAT >= 2) begin : g_lat2
    logic              rsp_v2_q;
    logic [DATA_W-1:0] rsp_d2_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rsp_v2_q <= 1'b0;
        rsp_d2_q <= '0;
      end else begin
        rsp_v2_q <= rsp_v1_q;
        if (rsp_v1_q) begin
          rsp_d2_q <= bank_out;
        end
      end
    end

    assign rd_rsp_valid = rsp_v2_q;
    assign rd_rsp_data  = rsp_d2_q;
  end else begin : g_lat1
    assign rd_rsp_valid = rsp_v1_q;
    assign rd_rsp_data  = bank_out;
  end

endmodule

// File: tb/tb_act_ring_mem.sv
// Bench for act_ring_mem: directed scenarios plus random traffic checked against a
// queue-based behavioural model of the bank ring.
module tb_act_ring_mem;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned NBANK  = 4;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned BW     = $clog2(NBANK);
  localparam int unsigned FW     = $clog2(NBANK + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0, wr_last = 1'b0, rd_valid = 1'b0, rd_release = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0, rd_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready, rd_ready, rd_rsp_valid, err;
  logic [DATA_W-1:0] rd_rsp_data;
  logic [BW-1:0]     wr_bank, rd_bank;
  logic [FW-1:0]     filled;
  logic [ADDR_W:0]   wr_words;

  always #5 clk = ~clk;

  act_ring_mem #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NBANK(NBANK), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_release(rd_release),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .filled(filled), .wr_words(wr_words), .err(err)
  );

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } rsp_t;

  rsp_t              pend[$];
  logic [DATA_W-1:0] got[$];
  logic [DATA_W-1:0] mm [NBANK][DEPTH];
  int                m_wr_bank, m_rd_bank, m_filled, m_wr_words, cyc;
  logic              m_err, exp_valid;
  logic [DATA_W-1:0] exp_data;
  int                vectors = 0, miscompares = 0;

  task automatic model_reset();
    m_wr_bank = 0; m_rd_bank = 0; m_filled = 0; m_wr_words = 0; m_err = 1'b0;
    exp_valid = 1'b0; exp_data = '0;
    pend.delete();
    got.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_valid = 1'b0; wr_last = 1'b0; rd_valid = 1'b0; rd_release = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock of stimulus; the model advances by the same cycle.
  task automatic tick(input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input logic wl, input logic rv, input logic [ADDR_W-1:0] ra,
                      input logic rel);
    logic wacc, racc, vrel;
    rsp_t r;
    wr_valid = wv; wr_addr = wa; wr_data = wd; wr_last = wl;
    rd_valid = rv; rd_addr = ra; rd_release = rel;
    wacc = wv && (m_filled < NBANK);
    racc = rv && (m_filled > 0);
    vrel = rel && (m_filled > 0);
    if ((rel && !vrel) || (wv && !wacc) || (rv && !racc)) m_err = 1'b1;
    if (racc) begin
      r.due = cyc + RD_LAT;
      r.data = mm[m_rd_bank][ra];
      pend.push_back(r);
    end
    if (wacc) begin
      mm[m_wr_bank][wa] = wd;
      if (m_wr_words == DEPTH) m_err = 1'b1;
      else m_wr_words++;
      if (wl) begin
        m_wr_words = 0;
        m_wr_bank = (m_wr_bank + 1) % NBANK;
        m_filled++;
      end
    end
    if (vrel) begin
      m_rd_bank = (m_rd_bank + 1) % NBANK;
      m_filled--;
    end
    @(posedge clk); #1;
    cyc++;
    exp_valid = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      exp_valid = 1'b1;
      exp_data = r.data;
    end
    if (rd_rsp_valid === 1'b1) got.push_back(rd_rsp_data);
    wr_valid = 1'b0; wr_last = 1'b0; rd_valid = 1'b0; rd_release = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, '0, '0, 0, 0, '0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    vectors += 9;
    if (rd_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0", rd_rsp_valid); end
    if (rd_rsp_data !== '0) begin miscompares++; $display("FAIL reset_rsp_data got %h want 0", rd_rsp_data); end
    if (wr_bank !== '0) begin miscompares++; $display("FAIL reset_wr_bank got %0d want 0", wr_bank); end
    if (rd_bank !== '0) begin miscompares++; $display("FAIL reset_rd_bank got %0d want 0", rd_bank); end
    if (filled !== '0) begin miscompares++; $display("FAIL reset_filled got %0d want 0", filled); end
    if (wr_words !== '0) begin miscompares++; $display("FAIL reset_wr_words got %0d want 0", wr_words); end
    if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
    if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    if (rd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_rd_ready got %b want 0", rd_ready); end
  endtask

  task automatic test_single_layer();
    for (int i = 0; i < 4; i++) tick(1, ADDR_W'(i), DATA_W'(16'hA0 + i), i == 3, 0, '0, 0);
    vectors += 3;
    if (wr_bank !== BW'(1)) begin miscompares++; $display("FAIL layer_wr_bank got %0d want 1", wr_bank); end
    if (filled !== FW'(1)) begin miscompares++; $display("FAIL layer_filled got %0d want 1", filled); end
    if (wr_words !== '0) begin miscompares++; $display("FAIL layer_wr_words got %0d want 0", wr_words); end
    tick(0, '0, '0, 0, 1, ADDR_W'(2), 0);
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      if (k > 1) idle(1);
      vectors++;
      if (rd_rsp_valid !== (k == RD_LAT)) begin
        miscompares++;
        $display("FAIL layer_rsp_timing cycle %0d got %b want %b", k, rd_rsp_valid, k == RD_LAT);
      end
      if (k == RD_LAT) begin
        vectors++;
        if (rd_rsp_data !== DATA_W'(16'hA2)) begin
          miscompares++; $display("FAIL layer_rsp_data got %h want a2", rd_rsp_data);
        end
      end
    end
  endtask

  task automatic test_overlap();
    got.delete();
    for (int i = 0; i < 4 + RD_LAT; i++) begin
      if (i < 4) tick(1, ADDR_W'(i), DATA_W'(16'hB0 + i), i == 3, 1, ADDR_W'(i), 0);
      else idle(1);
      vectors++;
      if (rd_rsp_valid !== exp_valid) begin
        miscompares++; $display("FAIL overlap_valid step %0d got %b want %b", i, rd_rsp_valid, exp_valid);
      end
    end
    vectors++;
    if (got.size() != 4) begin miscompares++; $display("FAIL overlap_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== DATA_W'(16'hA0 + i)) begin
        miscompares++; $display("FAIL overlap_data[%0d] got %h want %h", i, got[i], 16'hA0 + i);
      end
    end
    vectors++;
    if (filled !== FW'(2)) begin miscompares++; $display("FAIL overlap_filled got %0d want 2", filled); end
  endtask

  task automatic test_full_stall();
    for (int k = 0; k < NBANK; k++)
      if (m_filled < NBANK) tick(1, '0, DATA_W'(16'hC000 + m_wr_bank), 1, 0, '0, 0);
    vectors += 3;
    if (filled !== FW'(NBANK)) begin miscompares++; $display("FAIL stall_filled got %0d want %0d", filled, NBANK); end
    if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL stall_wr_ready got %b want 0", wr_ready); end
    if (err !== 1'b0) begin miscompares++; $display("FAIL stall_err_early got %b want 0", err); end
    // Dropped write aims at bank 0 addr 2, which still holds unreleased data.
    tick(1, ADDR_W'(2), DATA_W'(16'hDEAD), 1, 0, '0, 0);
    vectors += 3;
    if (err !== 1'b1) begin miscompares++; $display("FAIL stall_err got %b want 1", err); end
    if (filled !== FW'(NBANK)) begin miscompares++; $display("FAIL stall_drop_filled got %0d want %0d", filled, NBANK); end
    if (wr_bank !== '0) begin miscompares++; $display("FAIL stall_drop_wr_bank got %0d want 0", wr_bank); end
    got.delete();
    tick(0, '0, '0, 0, 1, ADDR_W'(2), 0);
    idle(RD_LAT);
    vectors++;
    if (got.size() != 1 || got[0] !== DATA_W'(16'hA2)) begin
      miscompares++; $display("FAIL stall_mem_intact got %0d words first %h want a2", got.size(), got.size() ? got[0] : '0);
    end
    tick(0, '0, '0, 0, 0, '0, 1);
    vectors += 3;
    if (filled !== FW'(NBANK - 1)) begin miscompares++; $display("FAIL stall_rel_filled got %0d want %0d", filled, NBANK - 1); end
    if (rd_bank !== BW'(1)) begin miscompares++; $display("FAIL stall_rel_rd_bank got %0d want 1", rd_bank); end
    if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL stall_rel_wr_ready got %b want 1", wr_ready); end
    got.delete();
    for (int i = 0; i < 4; i++) tick(0, '0, '0, 0, 1, ADDR_W'(i), 0);
    idle(RD_LAT);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= got.size() || got[i] !== DATA_W'(16'hB0 + i)) begin
        miscompares++; $display("FAIL stall_bank1[%0d] got %h want %h", i, i < got.size() ? got[i] : '0, 16'hB0 + i);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, ADDR_W'(i), DATA_W'(16'h50 + i), i == 3, 0, '0, 0);
    for (int i = 0; i < 3; i++) tick(1, ADDR_W'(i), DATA_W'(16'h60 + i), 0, 0, '0, 0);
    got.delete();
    tick(1, ADDR_W'(3), DATA_W'(16'h63), 1, 1, ADDR_W'(1), 1);
    vectors += 3;
    if (filled !== FW'(1)) begin miscompares++; $display("FAIL simul_filled got %0d want 1", filled); end
    if (wr_bank !== BW'(2)) begin miscompares++; $display("FAIL simul_wr_bank got %0d want 2", wr_bank); end
    if (rd_bank !== BW'(1)) begin miscompares++; $display("FAIL simul_rd_bank got %0d want 1", rd_bank); end
    tick(0, '0, '0, 0, 1, ADDR_W'(3), 0);
    idle(RD_LAT);
    vectors++;
    if (got.size() != 2 || got[0] !== DATA_W'(16'h51) || got[1] !== DATA_W'(16'h63)) begin
      miscompares++;
      $display("FAIL simul_data got %0d words %h %h want 51 63", got.size(),
               got.size() > 0 ? got[0] : '0, got.size() > 1 ? got[1] : '0);
    end
  endtask

  task automatic test_wrap();
    logic [DATA_W-1:0] tag;
    do_reset();
    for (int it = 0; it < 6; it++) begin
      vectors += 2;
      if (wr_bank !== BW'(it % NBANK)) begin miscompares++; $display("FAIL wrap_wr_bank it %0d got %0d want %0d", it, wr_bank, it % NBANK); end
      if (rd_bank !== BW'(it % NBANK)) begin miscompares++; $display("FAIL wrap_rd_bank it %0d got %0d want %0d", it, rd_bank, it % NBANK); end
      for (int a = 0; a < 2; a++)
        tick(1, ADDR_W'(a), DATA_W'(((it % NBANK) << 12) | (it << 8) | a), a == 1, 0, '0, 0);
      got.delete();
      for (int a = 0; a < 2; a++) tick(0, '0, '0, 0, 1, ADDR_W'(a), 0);
      idle(RD_LAT);
      for (int a = 0; a < 2; a++) begin
        tag = DATA_W'(((it % NBANK) << 12) | (it << 8) | a);
        vectors++;
        if (a >= got.size() || got[a] !== tag) begin
          miscompares++; $display("FAIL wrap_data it %0d addr %0d got %h want %h", it, a, a < got.size() ? got[a] : '0, tag);
        end
      end
      tick(0, '0, '0, 0, 0, '0, 1);
    end
  endtask

  task automatic test_errors();
    do_reset();
    tick(0, '0, '0, 1, 0, '0, 0);
    vectors += 3;
    if (wr_bank !== '0) begin miscompares++; $display("FAIL lone_last_wr_bank got %0d want 0", wr_bank); end
    if (filled !== '0) begin miscompares++; $display("FAIL lone_last_filled got %0d want 0", filled); end
    if (err !== 1'b0) begin miscompares++; $display("FAIL lone_last_err got %b want 0", err); end
    for (int i = 0; i < DEPTH; i++) tick(1, ADDR_W'(i), DATA_W'(i), 0, 0, '0, 0);
    vectors += 2;
    if (wr_words !== (ADDR_W + 1)'(DEPTH)) begin miscompares++; $display("FAIL ovf_words_full got %0d want %0d", wr_words, DEPTH); end
    if (err !== 1'b0) begin miscompares++; $display("FAIL ovf_err_early got %b want 0", err); end
    tick(1, '0, DATA_W'(16'h77), 0, 0, '0, 0);
    vectors += 2;
    if (wr_words !== (ADDR_W + 1)'(DEPTH)) begin miscompares++; $display("FAIL ovf_words_sat got %0d want %0d", wr_words, DEPTH); end
    if (err !== 1'b1) begin miscompares++; $display("FAIL ovf_err got %b want 1", err); end
    do_reset();
    got.delete();
    tick(0, '0, '0, 0, 1, '0, 0);
    idle(RD_LAT + 1);
    vectors += 2;
    if (err !== 1'b1) begin miscompares++; $display("FAIL rd_empty_err got %b want 1", err); end
    if (got.size() != 0) begin miscompares++; $display("FAIL rd_empty_rsp got %0d responses want 0", got.size()); end
    do_reset();
    tick(0, '0, '0, 0, 0, '0, 1);
    vectors += 3;
    if (err !== 1'b1) begin miscompares++; $display("FAIL rel_empty_err got %b want 1", err); end
    if (rd_bank !== '0) begin miscompares++; $display("FAIL rel_empty_rd_bank got %0d want 0", rd_bank); end
    if (filled !== '0) begin miscompares++; $display("FAIL rel_empty_filled got %0d want 0", filled); end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    tick(1, '0, DATA_W'(16'h99), 1, 0, '0, 0);
    tick(0, '0, '0, 0, 1, '0, 0);
    rst = 1'b1;
    #2;
    vectors += 5;
    if (rd_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got %b want 0", rd_rsp_valid); end
    if (rd_rsp_data !== '0) begin miscompares++; $display("FAIL midrst_data got %h want 0", rd_rsp_data); end
    if (filled !== '0) begin miscompares++; $display("FAIL midrst_filled got %0d want 0", filled); end
    if (wr_bank !== '0) begin miscompares++; $display("FAIL midrst_wr_bank got %0d want 0", wr_bank); end
    if (err !== 1'b0) begin miscompares++; $display("FAIL midrst_err got %b want 0", err); end
    do_reset();
    for (int i = 0; i < RD_LAT + 2; i++) begin
      idle(1);
      vectors++;
      if (rd_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_late_valid cycle %0d got %b want 0", i, rd_rsp_valid); end
    end
  endtask

  task automatic test_random();
    logic wv, rv, rel, wl;
    do_reset();
    for (int b = 0; b < NBANK; b++) begin
      for (int a = 0; a < DEPTH; a++)
        tick(1, ADDR_W'(a), DATA_W'($urandom), a == DEPTH - 1, 0, '0, 0);
      tick(0, '0, '0, 0, 0, '0, 1);
    end
    for (int n = 0; n < 1500; n++) begin
      wv  = ($urandom_range(0, 1) == 1) && (m_filled < NBANK || $urandom_range(0, 15) == 0);
      rv  = ($urandom_range(0, 1) == 1) && (m_filled > 0 || $urandom_range(0, 15) == 0);
      rel = ($urandom_range(0, 7) == 0) && (m_filled > 0 || $urandom_range(0, 15) == 0);
      wl  = ($urandom_range(0, 5) == 0);
      tick(wv, ADDR_W'($urandom), DATA_W'($urandom), wl, rv, ADDR_W'($urandom), rel);
      vectors += 9;
      if (rd_rsp_valid !== exp_valid) begin miscompares++; $display("FAIL rnd_valid n %0d got %b want %b", n, rd_rsp_valid, exp_valid); end
      if (rd_rsp_data !== exp_data) begin miscompares++; $display("FAIL rnd_data n %0d got %h want %h", n, rd_rsp_data, exp_data); end
      if (wr_bank !== BW'(m_wr_bank)) begin miscompares++; $display("FAIL rnd_wr_bank n %0d got %0d want %0d", n, wr_bank, m_wr_bank); end
      if (rd_bank !== BW'(m_rd_bank)) begin miscompares++; $display("FAIL rnd_rd_bank n %0d got %0d want %0d", n, rd_bank, m_rd_bank); end
      if (filled !== FW'(m_filled)) begin miscompares++; $display("FAIL rnd_filled n %0d got %0d want %0d", n, filled, m_filled); end
      if (wr_words !== (ADDR_W + 1)'(m_wr_words)) begin miscompares++; $display("FAIL rnd_wr_words n %0d got %0d want %0d", n, wr_words, m_wr_words); end
      if (err !== m_err) begin miscompares++; $display("FAIL rnd_err n %0d got %b want %b", n, err, m_err); end
      if (wr_ready !== (m_filled < NBANK)) begin miscompares++; $display("FAIL rnd_wr_ready n %0d got %b", n, wr_ready); end
      if (rd_ready !== (m_filled > 0)) begin miscompares++; $display("FAIL rnd_rd_ready n %0d got %b", n, rd_ready); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    model_reset();
    test_reset();
    test_single_layer();
    test_overlap();
    test_full_stall();
    test_simultaneous();
    test_wrap();
    test_errors();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
